// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_run_ctrl
//  Description : Run sequencer for the single-cycle rv32is core.
//                - While the core is idle, the host loads program words into
//                  instruction memory through a valid/ready write port.
//                - A start command holds the core in reset for RST_HOLD cycles
//                  and then releases it.
//                - During the run, the block counts cycles and retired
//                  instructions.
//                - The run ends when the core reports done or the optional
//                  cycle budget is exhausted. The host may also abort it.
//  Ports       :
//    clk, rst                 clock, synchronous active-high reset
//    host_wvalid/host_wready  host program-word write handshake
//    host_waddr/host_wdata    word address / instruction word
//    host_start, host_abort   run control (start is level-sampled)
//    imem_we/waddr/wdata      registered instruction-memory write port
//    cpu_rst                  reset to the core (low only while running)
//    cpu_done, cpu_wb         core done flag / retire strobe
//    cpu_dbg_pc               core program counter for capture
//    state                    0 IDLE, 1 HOLD, 2 RUN, 3 DONE, 4 TIMEOUT
//    cycle_count              RUN cycles elapsed (saturating)
//    retired_count            instructions retired during RUN
//    final_pc                 pc captured at done / timeout
//    finished                 one-cycle pulse on entry to DONE or TIMEOUT
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_run_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int RST_HOLD   = 2,
  parameter int MAX_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_wvalid,
  output logic              host_wready,
  input  logic [ADDR_W-1:0] host_waddr,
  input  logic [31:0]       host_wdata,
  input  logic              host_start,
  input  logic              host_abort,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  input  logic              cpu_done,
  input  logic              cpu_wb,
  input  logic [31:0]       cpu_dbg_pc,
  output logic [2:0]        state,
  output logic [31:0]       cycle_count,
  output logic [31:0]       retired_count,
  output logic [31:0]       final_pc,
  output logic              finished
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  // Hold counter runs 0 .. RST_HOLD-1; a 1-bit counter suffices for RST_HOLD<=2.
  localparam int                   c_HOLD_W     = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST  = c_HOLD_W'(RST_HOLD - 1);
  localparam logic [c_HOLD_W-1:0]  c_HOLD_ONE   = c_HOLD_W'(1);
  localparam logic                 c_TIMEOUT_EN = (MAX_CYCLES != 0);
  // Timeout fires on the RUN cycle whose pre-increment count is MAX_CYCLES-1,
  // so the count reads exactly MAX_CYCLES once TIMEOUT is entered.
  localparam logic [31:0]          c_TIMEOUT_AT = 32'(MAX_CYCLES - 1);
  localparam logic [31:0]          c_CNT_MAX    = 32'hFFFF_FFFF;

  state_t              r_state;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic                r_cpu_rst;
  logic [31:0]         r_cycle_count;
  logic [31:0]         r_retired_count;
  logic [31:0]         r_final_pc;
  logic                r_finished;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_waddr;
  logic [31:0]         r_imem_wdata;

  logic                w_idle_like;
  logic                w_wr_accept;
  logic                w_timeout_hit;
  logic [31:0]         w_cycle_next;

  // Writes are only taken while the core is parked, and never in the same
  // cycle as a start, so a program word cannot race the reset release.
  assign w_idle_like   = (r_state == S_IDLE) || (r_state == S_DONE) ||
                         (r_state == S_TIMEOUT);
  assign host_wready   = w_idle_like && !host_start;
  assign w_wr_accept   = host_wvalid && host_wready;

  assign w_timeout_hit = c_TIMEOUT_EN && (r_cycle_count == c_TIMEOUT_AT);
  assign w_cycle_next  = (r_cycle_count == c_CNT_MAX) ? r_cycle_count
                                                      : r_cycle_count + 32'd1;

  // --------------------------------------------------------------------------
  // Instruction-memory write port: one registered beat per accepted request.
  // Address/data hold their last value when no write is in flight.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_imem_we    <= 1'b0;
      r_imem_waddr <= '0;
      r_imem_wdata <= 32'd0;
    end else begin
      r_imem_we <= w_wr_accept;
      if (w_wr_accept) begin
        r_imem_waddr <= host_waddr;
        r_imem_wdata <= host_wdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Run sequencer with registered outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_hold_cnt      <= '0;
      r_cpu_rst       <= 1'b1;
      r_cycle_count   <= 32'd0;
      r_retired_count <= 32'd0;
      r_final_pc      <= 32'd0;
      r_finished      <= 1'b0;
    end else begin
      r_finished <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (host_start) begin
            r_state         <= S_HOLD;
            r_hold_cnt      <= '0;
            r_cpu_rst       <= 1'b1;
            r_cycle_count   <= 32'd0;
            r_retired_count <= 32'd0;
            r_final_pc      <= 32'd0;
          end
        end

        S_HOLD: begin
          if (host_abort) begin
            r_state   <= S_IDLE;
            r_cpu_rst <= 1'b1;
          end else if (r_hold_cnt == c_HOLD_LAST) begin
            // Drop the core reset together with the state change so the core
            // is out of reset on the very first RUN cycle.
            r_state   <= S_RUN;
            r_cpu_rst <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
          end
        end

        S_RUN: begin
          // Abort wins over done/timeout and freezes the counters as they are.
          if (host_abort) begin
            r_state   <= S_IDLE;
            r_cpu_rst <= 1'b1;
          end else begin
            r_cycle_count <= w_cycle_next;
            // The retire strobe in the done cycle belongs to the halting
            // instruction and is not counted.
            if (cpu_wb && !cpu_done) begin
              r_retired_count <= r_retired_count + 32'd1;
            end
            if (cpu_done) begin
              r_state    <= S_DONE;
              r_final_pc <= cpu_dbg_pc;
              r_finished <= 1'b1;
              r_cpu_rst  <= 1'b1;
            end else if (w_timeout_hit) begin
              r_state    <= S_TIMEOUT;
              r_final_pc <= cpu_dbg_pc;
              r_finished <= 1'b1;
              r_cpu_rst  <= 1'b1;
            end
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_cpu_rst <= 1'b1;
        end
      endcase
    end
  end

  assign imem_we       = r_imem_we;
  assign imem_waddr    = r_imem_waddr;
  assign imem_wdata    = r_imem_wdata;
  assign cpu_rst       = r_cpu_rst;
  assign state         = r_state;
  assign cycle_count   = r_cycle_count;
  assign retired_count = r_retired_count;
  assign final_pc      = r_final_pc;
  assign finished      = r_finished;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_run_ctrl
//  Description : Self-checking bench for cpu_run_ctrl. Two instances share one
//                stimulus stream: A has no timeout, B has MAX_CYCLES=5.
//                A reference model tracks both instances cycle by cycle.
//                Directed checks pin the key scenarios to literal values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_run_ctrl;

  localparam int c_AW = 10;

  logic clk;
  logic rst;
  logic host_wvalid;
  logic [c_AW-1:0] host_waddr;
  logic [31:0] host_wdata;
  logic host_start;
  logic host_abort;
  logic cpu_done;
  logic cpu_wb;
  logic [31:0] cpu_dbg_pc;

  logic wready_a, we_a, crst_a, fin_a;
  logic [c_AW-1:0] waddr_a;
  logic [31:0] wdata_a, cyc_a, ret_a, fpc_a;
  logic [2:0] st_a;

  logic wready_b, we_b, crst_b, fin_b;
  logic [c_AW-1:0] waddr_b;
  logic [31:0] wdata_b, cyc_b, ret_b, fpc_b;
  logic [2:0] st_b;

  cpu_run_ctrl #(.ADDR_W(c_AW), .RST_HOLD(2), .MAX_CYCLES(0)) u_dut_a (
    .clk(clk), .rst(rst),
    .host_wvalid(host_wvalid), .host_wready(wready_a),
    .host_waddr(host_waddr), .host_wdata(host_wdata),
    .host_start(host_start), .host_abort(host_abort),
    .imem_we(we_a), .imem_waddr(waddr_a), .imem_wdata(wdata_a),
    .cpu_rst(crst_a), .cpu_done(cpu_done), .cpu_wb(cpu_wb), .cpu_dbg_pc(cpu_dbg_pc),
    .state(st_a), .cycle_count(cyc_a), .retired_count(ret_a),
    .final_pc(fpc_a), .finished(fin_a)
  );

  cpu_run_ctrl #(.ADDR_W(c_AW), .RST_HOLD(2), .MAX_CYCLES(5)) u_dut_b (
    .clk(clk), .rst(rst),
    .host_wvalid(host_wvalid), .host_wready(wready_b),
    .host_waddr(host_waddr), .host_wdata(host_wdata),
    .host_start(host_start), .host_abort(host_abort),
    .imem_we(we_b), .imem_waddr(waddr_b), .imem_wdata(wdata_b),
    .cpu_rst(crst_b), .cpu_done(cpu_done), .cpu_wb(cpu_wb), .cpu_dbg_pc(cpu_dbg_pc),
    .state(st_b), .cycle_count(cyc_b), .retired_count(ret_b),
    .final_pc(fpc_b), .finished(fin_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int fin_cnt_a = 0;
  int fin_cnt_b = 0;
  bit armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: what the outputs must read after each clock edge.
  // ---------------------------------------------------------------------------
  localparam int M_IDLE = 0, M_HOLD = 1, M_RUN = 2, M_DONE = 3, M_TIMEOUT = 4;

  typedef struct {
    int          st;
    int          hold_left;
    logic [31:0] cyc;
    logic [31:0] ret;
    logic [31:0] fpc;
    logic        fin;
    logic        we;
    logic [c_AW-1:0] waddr;
    logic [31:0] wdata;
    logic        crst;
  } mdl_t;

  function automatic bit parked(input int s);
    return (s == M_IDLE) || (s == M_DONE) || (s == M_TIMEOUT);
  endfunction

  function automatic mdl_t step(input mdl_t m, input int maxc, input logic r,
                                input logic wv, input logic [c_AW-1:0] wa,
                                input logic [31:0] wd, input logic start,
                                input logic abort, input logic done,
                                input logic wb, input logic [31:0] pc);
    mdl_t n;
    n = m;
    if (r) begin
      n.st = M_IDLE; n.hold_left = 0; n.cyc = 0; n.ret = 0; n.fpc = 0;
      n.fin = 0; n.we = 0; n.waddr = '0; n.wdata = 0; n.crst = 1;
      return n;
    end
    n.fin = 1'b0;
    n.we  = parked(m.st) && !start && wv;
    if (n.we) begin
      n.waddr = wa;
      n.wdata = wd;
    end
    if (parked(m.st)) begin
      if (start) begin
        n.st = M_HOLD; n.hold_left = 2; n.cyc = 0; n.ret = 0; n.fpc = 0; n.crst = 1;
      end
    end else if (abort) begin
      n.st = M_IDLE;
      n.crst = 1;
    end else if (m.st == M_HOLD) begin
      n.hold_left = m.hold_left - 1;
      if (n.hold_left == 0) begin
        n.st = M_RUN;
        n.crst = 0;
      end
    end else begin
      n.cyc = (m.cyc == 32'hFFFF_FFFF) ? m.cyc : m.cyc + 32'd1;
      if (wb && !done) n.ret = m.ret + 32'd1;
      if (done || (maxc != 0 && m.cyc == 32'(maxc - 1))) begin
        n.st   = done ? M_DONE : M_TIMEOUT;
        n.fpc  = pc;
        n.fin  = 1'b1;
        n.crst = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic cmp_all(input string t, input mdl_t m, input logic wr,
                         input logic we, input logic [c_AW-1:0] wa,
                         input logic [31:0] wd, input logic cr, input logic [2:0] st,
                         input logic [31:0] cyc, input logic [31:0] ret,
                         input logic [31:0] fpc, input logic fin);
    chk({t, ".state"}, {29'd0, st}, 32'(m.st));
    chk({t, ".cpu_rst"}, {31'd0, cr}, {31'd0, m.crst});
    chk({t, ".wready"}, {31'd0, wr}, {31'd0, parked(m.st) && !host_start});
    chk({t, ".imem_we"}, {31'd0, we}, {31'd0, m.we});
    chk({t, ".imem_waddr"}, 32'(wa), 32'(m.waddr));
    chk({t, ".imem_wdata"}, wd, m.wdata);
    chk({t, ".cycle_count"}, cyc, m.cyc);
    chk({t, ".retired_count"}, ret, m.ret);
    chk({t, ".final_pc"}, fpc, m.fpc);
    chk({t, ".finished"}, {31'd0, fin}, {31'd0, m.fin});
  endtask

  mdl_t ma, mb;

  always @(posedge clk) begin
    if (rst) armed = 1'b1;
    ma = step(ma, 0, rst, host_wvalid, host_waddr, host_wdata, host_start,
              host_abort, cpu_done, cpu_wb, cpu_dbg_pc);
    mb = step(mb, 5, rst, host_wvalid, host_waddr, host_wdata, host_start,
              host_abort, cpu_done, cpu_wb, cpu_dbg_pc);
    #1;
    if (armed) begin
      cmp_all("A", ma, wready_a, we_a, waddr_a, wdata_a, crst_a, st_a, cyc_a, ret_a, fpc_a, fin_a);
      cmp_all("B", mb, wready_b, we_b, waddr_b, wdata_b, crst_b, st_b, cyc_b, ret_b, fpc_b, fin_b);
      if (fin_a) fin_cnt_a++;
      if (fin_b) fin_cnt_b++;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations (inputs change on negedge).
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_to_run();
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    tick();
    tick();
  endtask

  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'h0010_0093;
    prog[1] = 32'h0020_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0010_0073;
    rst = 1'b1; host_wvalid = 1'b0; host_waddr = '0; host_wdata = 32'd0;
    host_start = 1'b0; host_abort = 1'b0; cpu_done = 1'b0; cpu_wb = 1'b0;
    cpu_dbg_pc = 32'd0;
    repeat (3) tick();
    chk("reset.state", {29'd0, st_a}, 32'd0);
    chk("reset.cpu_rst", {31'd0, crst_a}, 32'd1);
    chk("reset.imem_we", {31'd0, we_a}, 32'd0);
    rst = 1'b0;

    // Four back-to-back program words, each visible one cycle later.
    for (int k = 0; k < 4; k++) begin
      host_wvalid = 1'b1;
      host_waddr  = c_AW'(k);
      host_wdata  = prog[k];
      tick();
      chk("load.we", {31'd0, we_a}, 32'd1);
      chk("load.waddr", 32'(waddr_a), 32'(k));
      chk("load.wdata", wdata_a, prog[k]);
    end
    host_wvalid = 1'b0;
    tick();
    chk("load.we_after", {31'd0, we_a}, 32'd0);

    // Start with a simultaneous write: the write must be refused.
    cpu_wb      = 1'b1;
    host_start  = 1'b1;
    host_wvalid = 1'b1;
    host_waddr  = 10'd5;
    host_wdata  = 32'hDEAD_BEEF;
    tick();
    chk("start.state_hold1", {29'd0, st_a}, 32'd1);
    chk("start.write_refused", {31'd0, we_a}, 32'd0);
    chk("start.cpu_rst_hold1", {31'd0, crst_a}, 32'd1);
    host_start  = 1'b0;
    host_wvalid = 1'b0;
    tick();
    chk("start.state_hold2", {29'd0, st_a}, 32'd1);
    chk("start.cpu_rst_hold2", {31'd0, crst_a}, 32'd1);
    tick();
    chk("start.state_run", {29'd0, st_a}, 32'd2);
    chk("start.cpu_rst_run", {31'd0, crst_a}, 32'd0);

    // Stub core: retires every cycle, done on the 10th RUN cycle.
    for (int k = 1; k <= 10; k++) begin
      cpu_dbg_pc = 32'h8000_0000 + 32'(4 * (k - 1));
      cpu_done   = (k == 10);
      tick();
    end
    cpu_done = 1'b0;
    chk("done.state", {29'd0, st_a}, 32'd3);
    chk("done.cycle_count", cyc_a, 32'd10);
    chk("done.retired_count", ret_a, 32'd9);
    chk("done.final_pc", fpc_a, 32'h8000_0024);
    chk("done.cpu_rst", {31'd0, crst_a}, 32'd1);
    chk("done.finished", {31'd0, fin_a}, 32'd1);
    chk("timeout.state", {29'd0, st_b}, 32'd4);
    chk("timeout.cycle_count", cyc_b, 32'd5);
    chk("timeout.retired_count", ret_b, 32'd5);
    chk("timeout.final_pc", fpc_b, 32'h8000_0010);
    chk("timeout.cpu_rst", {31'd0, crst_b}, 32'd1);
    tick();
    chk("done.finished_drop", {31'd0, fin_a}, 32'd0);
    chk("done.finish_pulses", 32'(fin_cnt_a), 32'd1);
    chk("timeout.finish_pulses", 32'(fin_cnt_b), 32'd1);

    // Abort on the third RUN cycle: back to IDLE, counters frozen, no pulse.
    start_to_run();
    for (int k = 1; k <= 3; k++) begin
      host_abort = (k == 3);
      tick();
    end
    host_abort = 1'b0;
    chk("abort.state", {29'd0, st_a}, 32'd0);
    chk("abort.cpu_rst", {31'd0, crst_a}, 32'd1);
    chk("abort.cycle_count", cyc_a, 32'd2);
    chk("abort.finish_pulses", 32'(fin_cnt_a), 32'd1);
    host_abort  = 1'b1;
    host_wvalid = 1'b1;
    host_waddr  = 10'd7;
    host_wdata  = 32'h1234_5678;
    tick();
    host_abort  = 1'b0;
    host_wvalid = 1'b0;
    chk("idle_abort.state", {29'd0, st_a}, 32'd0);
    chk("idle_write.we", {31'd0, we_a}, 32'd1);
    chk("idle_write.waddr", 32'(waddr_a), 32'd7);

    // Done and timeout on the same cycle: DONE wins in instance B.
    start_to_run();
    for (int k = 1; k <= 5; k++) begin
      cpu_dbg_pc = (k == 5) ? 32'h8000_0100 : 32'h8000_0000;
      cpu_done   = (k == 5);
      tick();
    end
    cpu_done = 1'b0;
    chk("tie.state_b", {29'd0, st_b}, 32'd3);
    chk("tie.final_pc_b", fpc_b, 32'h8000_0100);
    chk("tie.retired_b", ret_b, 32'd4);

    // Reset mid-RUN while instance B (in TIMEOUT) accepts a write.
    start_to_run();
    repeat (7) tick();
    host_wvalid = 1'b1;
    host_waddr  = 10'd9;
    host_wdata  = 32'hCAFE_F00D;
    rst         = 1'b1;
    #1;
    chk("prerst.wready_a", {31'd0, wready_a}, 32'd0);
    chk("prerst.wready_b", {31'd0, wready_b}, 32'd1);
    chk("prerst.state_a", {29'd0, st_a}, 32'd2);
    tick();
    chk("rst.state_a", {29'd0, st_a}, 32'd0);
    chk("rst.cycle_a", cyc_a, 32'd0);
    chk("rst.cpu_rst_a", {31'd0, crst_a}, 32'd1);
    chk("rst.we_b", {31'd0, we_b}, 32'd0);
    chk("rst.waddr_b", 32'(waddr_b), 32'd0);
    chk("rst.wdata_b", wdata_b, 32'd0);
    chk("rst.final_pc_b", fpc_b, 32'd0);
    rst = 1'b0;
    host_wvalid = 1'b0;
    cpu_wb = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
